// File: rtl/sd_req_arbiter_if.sv
// Bundle of requester-side and mist_io-side signals shared by sd_req_arbiter.
// master is the arbiter's view; slave is the view of whatever surrounds it.
interface sd_req_arbiter_if #(
    parameter int unsigned NREQ = 4
);
    logic [NREQ-1:0]      req_rd;
    logic [NREQ-1:0]      req_wr;
    logic [NREQ-1:0]      req_drive;
    logic [32*NREQ-1:0]   req_lba;
    logic [8*NREQ-1:0]    req_buff_din;
    logic [NREQ-1:0]      req_busy;
    logic [NREQ-1:0]      req_done;
    logic [NREQ-1:0]      req_err;
    logic [NREQ-1:0]      req_buff_wr;
    logic [31:0]          sd_lba;
    logic [1:0]           sd_rd;
    logic [1:0]           sd_wr;
    logic                 sd_ack;
    logic                 sd_buff_wr;
    logic [7:0]           sd_buff_din;

    modport master (
        input  req_rd, req_wr, req_drive, req_lba, req_buff_din, sd_ack, sd_buff_wr,
        output req_busy, req_done, req_err, req_buff_wr, sd_lba, sd_rd, sd_wr, sd_buff_din
    );

    modport slave (
        output req_rd, req_wr, req_drive, req_lba, req_buff_din, sd_ack, sd_buff_wr,
        input  req_busy, req_done, req_err, req_buff_wr, sd_lba, sd_rd, sd_wr, sd_buff_din
    );
endinterface

// File: rtl/sd_req_arbiter.sv
// Round-robin sharing of the mist_io SD sector interface between NREQ requesters,
// one sector op at a time, with an ack-wait watchdog.
module sd_req_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TO_BITS = 24
) (
    input  logic          clk_sys_i,
    input  logic          reset_ni,
    sd_req_arbiter_if.master bus
);
    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StReq  = 2'd1;
    localparam logic [1:0] StXfer = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [PW-1:0]      g_q, g_d;
    logic [PW-1:0]      rr_q, rr_d;
    logic               drive_q, drive_d;
    logic               op_q, op_d;
    logic [31:0]        lba_q, lba_d;
    logic [TO_BITS-1:0] wd_q, wd_d;
    logic [NREQ-1:0]    busy_q, busy_d;
    logic [NREQ-1:0]    done_q, done_d;
    logic [NREQ-1:0]    err_q, err_d;
    logic [1:0]         rd_q, rd_d;
    logic [1:0]         wr_q, wr_d;

    logic [31:0]        lba_arr [NREQ];
    logic [7:0]         din_arr [NREQ];
    logic [NREQ-1:0]    pend;
    logic               found;
    logic [PW-1:0]      gsel;
    logic [PW-1:0]      rr_inc;
    logic [TO_BITS-1:0] wd_inc;
    logic [NREQ-1:0]    g_oh;
    logic               in_xfer;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            lba_arr[i] = bus.req_lba[32*i +: 32];
            din_arr[i] = bus.req_buff_din[8*i +: 8];
        end
    end

    assign pend = bus.req_rd | bus.req_wr;

    // First pending requester at or above rr_q, wrapping modulo NREQ.
    always_comb begin
        int           idx;
        logic [PW-1:0] idx_v;
        found = 1'b0;
        gsel  = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx   = (int'(rr_q) + k) % int'(NREQ);
            idx_v = idx[PW-1:0];
            if (!found && pend[idx_v]) begin
                found = 1'b1;
                gsel  = idx_v;
            end
        end
    end

    assign rr_inc  = (int'(g_q) == int'(NREQ) - 1) ? '0 : g_q + PW'(1);
    assign wd_inc  = wd_q + TO_BITS'(1);
    assign g_oh    = NREQ'(1) << g_q;
    assign in_xfer = (state_q == StXfer);

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        rr_d    = rr_q;
        drive_d = drive_q;
        op_d    = op_q;
        lba_d   = lba_q;
        wd_d    = wd_q;
        busy_d  = busy_q;
        done_d  = '0;
        err_d   = '0;
        rd_d    = rd_q;
        wr_d    = wr_q;
        case (state_q)
            StIdle: begin
                if (found) begin
                    g_d     = gsel;
                    op_d    = bus.req_wr[gsel];
                    drive_d = bus.req_drive[gsel];
                    lba_d   = lba_arr[gsel];
                    busy_d  = NREQ'(1) << gsel;
                    wd_d    = '0;
                    rd_d    = bus.req_wr[gsel] ? 2'b00 : (2'b01 << bus.req_drive[gsel]);
                    wr_d    = bus.req_wr[gsel] ? (2'b01 << bus.req_drive[gsel]) : 2'b00;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (bus.sd_ack) begin
                    rd_d    = 2'b00;
                    wr_d    = 2'b00;
                    state_d = StXfer;
                end else begin
                    wd_d = wd_inc;
                    if (&wd_inc) begin
                        err_d   = g_oh;
                        busy_d  = '0;
                        rd_d    = 2'b00;
                        wr_d    = 2'b00;
                        rr_d    = rr_inc;
                        state_d = StIdle;
                    end
                end
            end
            StXfer: begin
                if (!bus.sd_ack) begin
                    // done pulse and busy release land together, visible during DONE
                    done_d  = g_oh;
                    busy_d  = '0;
                    rr_d    = rr_inc;
                    state_d = StDone;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_sys_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= StIdle;
            g_q     <= '0;
            rr_q    <= '0;
            drive_q <= 1'b0;
            op_q    <= 1'b0;
            lba_q   <= '0;
            wd_q    <= '0;
            busy_q  <= '0;
            done_q  <= '0;
            err_q   <= '0;
            rd_q    <= 2'b00;
            wr_q    <= 2'b00;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            rr_q    <= rr_d;
            drive_q <= drive_d;
            op_q    <= op_d;
            lba_q   <= lba_d;
            wd_q    <= wd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
        end
    end

    assign bus.req_busy    = busy_q;
    assign bus.req_done    = done_q;
    assign bus.req_err     = err_q;
    assign bus.sd_rd       = rd_q;
    assign bus.sd_wr       = wr_q;
    assign bus.sd_lba      = (state_q == StReq || in_xfer) ? lba_q : 32'h0;
    assign bus.req_buff_wr = (in_xfer && bus.sd_buff_wr) ? g_oh : '0;
    assign bus.sd_buff_din = in_xfer ? din_arr[g_q] : 8'h00;
endmodule

// File: tb/tb_sd_req_arbiter.sv
// Randomized and directed checks of sd_req_arbiter against a transaction-level
// round-robin model.
module tb_sd_req_arbiter;
    localparam int NREQ    = 4;
    localparam int TO_BITS = 4;
    localparam int TO_CYC  = (1 << TO_BITS) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    sd_req_arbiter_if #(.NREQ(NREQ)) bus ();

    sd_req_arbiter #(
        .NREQ   (NREQ),
        .TO_BITS(TO_BITS)
    ) dut (
        .clk_sys_i(clk),
        .reset_ni (rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int rr_m  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [3:0] pend, input int rr);
        for (int k = 0; k < NREQ; k++) begin
            if (pend[(rr + k) % NREQ]) return (rr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input logic rd, input logic wr, input logic drv,
                           input logic [31:0] lba, input logic [7:0] din);
        bus.req_rd[i]             = rd;
        bus.req_wr[i]             = wr;
        bus.req_drive[i]          = drv;
        bus.req_lba[32*i +: 32]   = lba;
        bus.req_buff_din[8*i +: 8] = din;
    endtask

    task automatic clear_reqs();
        bus.req_rd = '0;
        bus.req_wr = '0;
    endtask

    task automatic random_reqs();
        int r;
        for (int i = 0; i < NREQ; i++) begin
            r = $urandom_range(0, 3);
            set_req(i, r[0], r[1], 1'($urandom_range(0, 1)), $urandom, 8'($urandom));
        end
        if ((bus.req_rd | bus.req_wr) == '0) bus.req_rd[$urandom_range(0, NREQ - 1)] = 1'b1;
    endtask

    // Called at a negedge with the DUT idle and requests already set.
    task automatic run_op(input bit timeout, input int pre, input int ackn, input bit hold);
        int          g;
        logic        opw, drv;
        logic [31:0] elba;
        logic [1:0]  erd, ewr;
        logic [3:0]  eoh;
        int          b, exp_cnt, obs_cnt, obs_other;
        g = pick(bus.req_rd | bus.req_wr, rr_m);
        if (g < 0) g = 0;
        opw  = bus.req_wr[g];
        drv  = bus.req_drive[g];
        elba = bus.req_lba[32*g +: 32];
        erd  = opw ? 2'b00 : (2'b01 << drv);
        ewr  = opw ? (2'b01 << drv) : 2'b00;
        eoh  = 4'(1 << g);
        @(posedge clk); @(negedge clk);
        chk("grant_busy", bus.req_busy, eoh);
        chk("grant_rd", bus.sd_rd, erd);
        chk("grant_wr", bus.sd_wr, ewr);
        chk("grant_lba", bus.sd_lba, elba);
        if (!hold) begin
            clear_reqs();
            for (int i = 0; i < NREQ; i++) bus.req_lba[32*i +: 32] = $urandom;
        end
        if (timeout) begin
            for (int c = 1; c <= TO_CYC; c++) begin
                bus.sd_buff_wr = 1'($urandom_range(0, 1));
                #1;
                chk("req_bwr_ignored", bus.req_buff_wr, 4'h0);
                @(posedge clk); @(negedge clk);
                if (c < TO_CYC) begin
                    chk("to_wait_err", bus.req_err, 4'h0);
                    chk("to_wait_rd", bus.sd_rd, erd);
                end else begin
                    chk("to_err", bus.req_err, eoh);
                    chk("to_busy", bus.req_busy, 4'h0);
                    chk("to_rd", bus.sd_rd, 2'b00);
                    chk("to_wr", bus.sd_wr, 2'b00);
                end
            end
            bus.sd_buff_wr = 1'b0;
            rr_m = (g + 1) % NREQ;
        end else begin
            for (int c = 0; c < pre; c++) begin
                bus.sd_buff_wr = 1'b1;
                #1;
                chk("req_bwr_ignored", bus.req_buff_wr, 4'h0);
                chk("req_din_zero", bus.sd_buff_din, 8'h00);
                @(posedge clk); @(negedge clk);
                chk("req_lba_hold", bus.sd_lba, elba);
            end
            bus.sd_buff_wr = 1'b0;
            bus.sd_ack     = 1'b1;
            @(posedge clk); @(negedge clk);
            chk("xfer_rd", bus.sd_rd, 2'b00);
            chk("xfer_wr", bus.sd_wr, 2'b00);
            chk("xfer_busy", bus.req_busy, eoh);
            exp_cnt = 0; obs_cnt = 0; obs_other = 0;
            for (int c = 0; c < ackn; c++) begin
                b = $urandom_range(0, 1);
                bus.sd_buff_wr = 1'(b);
                #1;
                chk("xfer_bwr", bus.req_buff_wr, (b != 0) ? eoh : 4'h0);
                chk("xfer_din", bus.sd_buff_din, bus.req_buff_din[8*g +: 8]);
                exp_cnt += b;
                if (bus.req_buff_wr[g]) obs_cnt++;
                if ((bus.req_buff_wr & ~eoh) != 4'h0) obs_other++;
                @(posedge clk); @(negedge clk);
            end
            chk("xfer_pulse_count", 64'(obs_cnt), 64'(exp_cnt));
            chk("xfer_stray_pulses", 64'(obs_other), 64'd0);
            bus.sd_buff_wr = 1'b0;
            bus.sd_ack     = 1'b0;
            @(posedge clk); @(negedge clk);
            chk("done_pulse", bus.req_done, eoh);
            chk("done_busy", bus.req_busy, 4'h0);
            chk("done_err", bus.req_err, 4'h0);
            rr_m = (g + 1) % NREQ;
            @(posedge clk); @(negedge clk);
            chk("done_clear", bus.req_done, 4'h0);
            chk("idle_busy", bus.req_busy, 4'h0);
        end
    endtask

    initial begin
        bus.req_rd       = '0;
        bus.req_wr       = '0;
        bus.req_drive    = '0;
        bus.req_lba      = '0;
        bus.req_buff_din = '0;
        bus.sd_ack       = 1'b0;
        bus.sd_buff_wr   = 1'b0;

        // Reset held with every requester asking to read on drive 0.
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b0, 1'b0, 32'h100 + 32'(i), 8'h00);
        repeat (3) @(negedge clk);
        chk("rst_rd", bus.sd_rd, 2'b00);
        chk("rst_wr", bus.sd_wr, 2'b00);
        chk("rst_busy", bus.req_busy, 4'h0);
        chk("rst_done", bus.req_done, 4'h0);
        chk("rst_err", bus.req_err, 4'h0);
        rst_n = 1'b1;
        rr_m  = 0;
        run_op(1'b0, 0, 3, 1'b0);

        // Single read on requester 2, drive 1, long transfer.
        set_req(2, 1'b1, 1'b0, 1'b1, 32'h1234, 8'h5C);
        run_op(1'b0, 2, 600, 1'b0);

        // All four hold read requests across five ops.
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b0, 1'($urandom_range(0, 1)), $urandom, 8'($urandom));
        repeat (5) run_op(1'b0, 1, 3, 1'b1);
        clear_reqs();

        // Write mux on requester 1.
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 1'b0, 1'b0, 32'h0, 8'h00);
        set_req(1, 1'b0, 1'b1, 1'b0, 32'hCAFE_0001, 8'hA5);
        run_op(1'b0, 1, 6, 1'b0);

        // Watchdog on requester 3.
        set_req(3, 1'b1, 1'b0, 1'b0, 32'h0000_0333, 8'h33);
        run_op(1'b1, 0, 0, 1'b0);

        // Reset in the middle of a transfer on requester 2.
        set_req(2, 1'b1, 1'b0, 1'b0, 32'h0000_0222, 8'h22);
        @(posedge clk); @(negedge clk);
        chk("mid_grant", bus.req_busy, 4'b0100);
        bus.sd_ack = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.sd_buff_wr = 1'b1;
        #1;
        chk("mid_bwr", bus.req_buff_wr, 4'b0100);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", bus.req_busy, 4'h0);
        chk("mid_rst_rd", bus.sd_rd, 2'b00);
        chk("mid_rst_bwr", bus.req_buff_wr, 4'h0);
        chk("mid_rst_din", bus.sd_buff_din, 8'h00);
        bus.sd_ack     = 1'b0;
        bus.sd_buff_wr = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rr_m  = 0;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b0, 1'b0, $urandom, 8'($urandom));
        run_op(1'b0, 0, 2, 1'b0);

        // Randomized traffic.
        for (int t = 0; t < 80; t++) begin
            random_reqs();
            run_op(($urandom_range(0, 5) == 0), $urandom_range(0, 3), $urandom_range(1, 8),
                   1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
